// File: rtl/ysyx_24110015_rd_responder.sv
// ysyx_24110015_rd_responder: register-file storage with an always-accepted write port
// and a valid/ready read port whose response follows after a fixed wait. Rev 1.0
`default_nettype none

module ysyx_24110015_rd_responder #(
   parameter int ADDR_W    = 4,
   parameter int DATA_W    = 32,
   parameter int LATENCY   = 2,
   parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wen,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              arvalid,
   output logic              arready,
   input  logic [ADDR_W-1:0] araddr,
   output logic              rvalid,
   input  logic              rready,
   output logic [DATA_W-1:0] rdata
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [3:0] CNT_START = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t              state, next_state;
   logic [3:0]          cnt, next_cnt;
   logic [ADDR_W-1:0]   cap_idx, next_cap_idx;
   logic [ADDR_W-1:0]   load_idx;
   logic                load_resp;
   logic [DATA_W-1:0]   rdata_q;
   logic [DATA_W-1:0]   mem [DEPTH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= RESET_VAL;
         end
      end else if (wen) begin
         mem[waddr] <= wdata;
      end
   end

   // The response load reads the pre-edge contents, so a same-edge write stays invisible.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= 4'd0;
         cap_idx <= '0;
         rdata_q <= '0;
      end else begin
         state   <= next_state;
         cnt     <= next_cnt;
         cap_idx <= next_cap_idx;
         if (load_resp) begin
            rdata_q <= mem[load_idx];
         end
      end
   end

   always_comb begin
      next_state   = state;
      next_cnt     = cnt;
      next_cap_idx = cap_idx;
      load_idx     = cap_idx;
      load_resp    = 1'b0;
      unique case (state)
         IDLE: begin
            if (arvalid) begin
               next_cap_idx = araddr;
               if (LATENCY == 0) begin
                  next_state = RESP;
                  next_cnt   = 4'd0;
                  load_idx   = araddr;
                  load_resp  = 1'b1;
               end else begin
                  next_state = WAIT;
                  next_cnt   = CNT_START;
               end
            end
         end
         WAIT: begin
            if (cnt == 4'd0) begin
               next_state = RESP;
               load_resp  = 1'b1;
            end else begin
               next_cnt = cnt - 4'd1;
            end
         end
         RESP: begin
            if (rready) begin
               next_state = IDLE;
            end
         end
         default: begin
            next_state = IDLE;
            next_cnt   = 4'd0;
         end
      endcase
   end

   assign arready = (state == IDLE);
   assign rvalid  = (state == RESP);
   assign rdata   = rdata_q;

endmodule

`default_nettype wire
